// File: rtl/e_mdu_if.sv
// Handshake and result bundle between the decode/E-stage control and the
// multiply/divide unit. The decoder side drives the request; the unit
// answers with busy, the architectural HI/LO and the mfhi/mflo read data.
interface e_mdu_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start,
        output md_op,
        output rs_data,
        output rt_data,
        output flush,
        input  busy,
        input  hi,
        input  lo,
        input  rd_data
    );

    modport slave (
        input  start,
        input  md_op,
        input  rs_data,
        input  rt_data,
        input  flush,
        output busy,
        output hi,
        output lo,
        output rd_data
    );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. Owns HI/LO, runs mult/multu/div/divu
// as fixed-latency multi-cycle operations, and handles mthi/mtlo/mfhi/mflo.
// The 64-bit result is computed on the accepting edge and parked in tmp_hi/
// tmp_lo; a down-counter models the iterative latency before it is committed.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;
    logic             wb_q, wb_d;

    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic is_mul_class, is_div_class;
    logic issue, accept;

    logic [63:0] prod_s, prod_u;
    logic        div_by_zero;
    logic [31:0] divisor_u;
    logic [31:0] quot_u, rem_u;
    logic [31:0] rs_mag, rt_mag, rt_mag_safe;
    logic [31:0] quot_mag, rem_mag;
    logic [31:0] quot_s, rem_s;
    logic [31:0] res_hi, res_lo;

    // Opcode decode; anything outside 1..8 decodes to nothing.
    always_comb begin
        is_mult  = 1'b0;
        is_multu = 1'b0;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        is_mfhi  = 1'b0;
        is_mflo  = 1'b0;
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        case (md.md_op)
            OP_MULT:  is_mult  = 1'b1;
            OP_MULTU: is_multu = 1'b1;
            OP_DIV:   is_div   = 1'b1;
            OP_DIVU:  is_divu  = 1'b1;
            OP_MFHI:  is_mfhi  = 1'b1;
            OP_MFLO:  is_mflo  = 1'b1;
            OP_MTHI:  is_mthi  = 1'b1;
            OP_MTLO:  is_mtlo  = 1'b1;
            default:  ;
        endcase
        is_mul_class = is_mult | is_multu;
        is_div_class = is_div | is_divu;
        issue        = md.start & ~md.flush & ~busy_q;
        accept       = issue & (is_mul_class | is_div_class);
    end

    // Arithmetic for the four long operations, evaluated every cycle and
    // captured only on an accepting edge.
    always_comb begin
        prod_s = {{32{md.rs_data[31]}}, md.rs_data} * {{32{md.rt_data[31]}}, md.rt_data};
        prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};

        div_by_zero = (md.rt_data == '0);

        // Unsigned divide; a zero divisor is replaced so the divider never
        // sees it (its result is discarded at completion anyway).
        divisor_u = div_by_zero ? 32'd1 : md.rt_data;
        quot_u    = md.rs_data / divisor_u;
        rem_u     = md.rs_data % divisor_u;

        // Signed divide as magnitude divide plus sign fix-up: quotient is
        // negative when operand signs differ, remainder follows the dividend.
        rs_mag      = md.rs_data[31] ? (32'd0 - md.rs_data) : md.rs_data;
        rt_mag      = md.rt_data[31] ? (32'd0 - md.rt_data) : md.rt_data;
        rt_mag_safe = div_by_zero ? 32'd1 : rt_mag;
        quot_mag    = rs_mag / rt_mag_safe;
        rem_mag     = rs_mag % rt_mag_safe;
        quot_s      = (md.rs_data[31] ^ md.rt_data[31]) ? (32'd0 - quot_mag) : quot_mag;
        rem_s       = md.rs_data[31] ? (32'd0 - rem_mag) : rem_mag;

        // Most-negative / -1 overflows; pin the architectural answer.
        if (md.rs_data == 32'h8000_0000 && md.rt_data == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = '0;
        end

        res_hi = '0;
        res_lo = '0;
        if (is_mult) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (is_multu) begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end else if (is_div) begin
            res_hi = rem_s;
            res_lo = quot_s;
        end else if (is_divu) begin
            res_hi = rem_u;
            res_lo = quot_u;
        end
    end

    // State, counter, HI/LO and staged result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            wb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            wb_q     <= wb_d;
        end
    end

    // Next-state: accept/launch in IDLE, count down and commit in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        wb_d     = wb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    // A divide by zero still occupies the full latency but
                    // leaves HI/LO untouched when it finishes.
                    wb_d     = ~(is_div_class & div_by_zero);
                    cnt_d    = is_mul_class ? MULT_LOAD : DIV_LOAD;
                    state_d  = RUN;
                end else if (issue && is_mthi) begin
                    hi_d = md.rs_data;
                end else if (issue && is_mtlo) begin
                    lo_d = md.rs_data;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (wb_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // Outputs: registered busy/HI/LO and the combinational mfhi/mflo read port.
    always_comb begin
        md.busy = busy_q;
        md.hi   = hi_q;
        md.lo   = lo_q;
        if (is_mfhi) begin
            md.rd_data = hi_q;
        end else if (is_mflo) begin
            md.rd_data = lo_q;
        end else begin
            md.rd_data = '0;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases followed by random
// operations, all checked against a plain-arithmetic HI/LO reference model.
module tb_e_mdu;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] mhi;
    logic [31:0] mlo;

    e_mdu_if mif ();

    e_mdu #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result {hi,lo} for a long op; divide by zero keeps current HI/LO.
    function automatic logic [63:0] ref_result(input int op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            1: begin
                p = 64'(sa * sb);
                return p;
            end
            2: return ua * ub;
            3: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (b == 32'd0) return cur;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return cur;
        endcase
    endfunction

    task automatic idle_inputs();
        mif.start   = 1'b0;
        mif.md_op   = 4'd0;
        mif.rs_data = '0;
        mif.rt_data = '0;
        mif.flush   = 1'b0;
    endtask

    // Issue one long op, measure busy length, check committed HI/LO.
    task automatic run_md(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int ncyc;
        int need;
        exp  = ref_result(op, a, b, {mhi, mlo});
        need = (op <= 2) ? int'(MC) : int'(DC);
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = 4'(op);
        mif.rs_data = a;
        mif.rt_data = b;
        @(negedge clk);
        idle_inputs();
        ncyc = 0;
        while (mif.busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(ncyc), 32'(need));
        mhi = exp[63:32];
        mlo = exp[31:0];
        check({tag, "_hi"}, mif.hi, mhi);
        check({tag, "_lo"}, mif.lo, mlo);
    endtask

    task automatic move_to(input int op, input logic [31:0] a, input string tag);
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = 4'(op);
        mif.rs_data = a;
        @(negedge clk);
        idle_inputs();
        if (op == 7) mhi = a;
        else mlo = a;
        check({tag, "_busy"}, 32'(mif.busy), 32'd0);
        check({tag, "_hi"}, mif.hi, mhi);
        check({tag, "_lo"}, mif.lo, mlo);
    endtask

    task automatic move_from(input int op, input string tag);
        @(negedge clk);
        mif.start = 1'b1;
        mif.md_op = 4'(op);
        #1;
        check({tag, "_rd"}, mif.rd_data, (op == 5) ? mhi : mlo);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic undefined_op(input int op, input logic [31:0] a, input string tag);
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = 4'(op);
        mif.rs_data = a;
        mif.rt_data = a;
        #1;
        check({tag, "_rd"}, mif.rd_data, 32'd0);
        @(negedge clk);
        idle_inputs();
        check({tag, "_busy"}, 32'(mif.busy), 32'd0);
        check({tag, "_hi"}, mif.hi, mhi);
        check({tag, "_lo"}, mif.lo, mlo);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] a, b;
        int op;
        int ncyc;

        checks   = 0;
        failures = 0;
        mhi      = '0;
        mlo      = '0;
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(mif.busy), 32'd0);
        check("reset_hi", mif.hi, 32'd0);
        check("reset_lo", mif.lo, 32'd0);
        reset = 1'b1;

        run_md(1, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        run_md(4, 32'd7, 32'd2, "divu_7_2");
        run_md(3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        move_to(7, 32'h1234_5678, "mthi");
        move_from(5, "mfhi");
        move_from(6, "mflo");
        run_md(3, 32'd99, 32'd0, "div_by_zero");
        run_md(4, 32'd5, 32'd0, "divu_by_zero");
        run_md(3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_md(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        undefined_op(9, 32'hDEAD_BEEF, "undef_op");

        // Second start during a running multu must be ignored.
        exp = ref_result(2, 32'h0001_0003, 32'h0002_0007, {mhi, mlo});
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = 4'd2;
        mif.rs_data = 32'h0001_0003;
        mif.rt_data = 32'h0002_0007;
        @(negedge clk);
        ncyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (mif.busy === 1'b1) ncyc++;
            if (i == 1) begin
                mif.start   = 1'b1;
                mif.md_op   = 4'd1;
                mif.rs_data = 32'd2;
                mif.rt_data = 32'd3;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        mhi = exp[63:32];
        mlo = exp[31:0];
        check("overlap_busy_cycles", 32'(ncyc), 32'(MC));
        check("overlap_hi", mif.hi, mhi);
        check("overlap_lo", mif.lo, mlo);

        // start with flush in the same cycle: nothing accepted.
        @(negedge clk);
        mif.start   = 1'b1;
        mif.flush   = 1'b1;
        mif.md_op   = 4'd1;
        mif.rs_data = 32'd4;
        mif.rt_data = 32'd4;
        @(negedge clk);
        idle_inputs();
        check("startflush_busy", 32'(mif.busy), 32'd0);
        @(negedge clk);
        check("startflush_hi", mif.hi, mhi);
        check("startflush_lo", mif.lo, mlo);

        // mtlo with flush must not write either.
        @(negedge clk);
        mif.start   = 1'b1;
        mif.flush   = 1'b1;
        mif.md_op   = 4'd8;
        mif.rs_data = 32'hCAFE_0001;
        @(negedge clk);
        idle_inputs();
        check("mtlo_flush_lo", mif.lo, mlo);

        // flush while running: op still completes.
        exp = ref_result(1, 32'd1000, 32'hFFFF_FF00, {mhi, mlo});
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = 4'd1;
        mif.rs_data = 32'd1000;
        mif.rt_data = 32'hFFFF_FF00;
        @(negedge clk);
        ncyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (mif.busy === 1'b1) ncyc++;
            idle_inputs();
            if (i == 1) mif.flush = 1'b1;
            @(negedge clk);
        end
        mhi = exp[63:32];
        mlo = exp[31:0];
        check("flushrun_busy_cycles", 32'(ncyc), 32'(MC));
        check("flushrun_hi", mif.hi, mhi);
        check("flushrun_lo", mif.lo, mlo);

        // Asynchronous reset on cycle 3 of a divide.
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = 4'd3;
        mif.rs_data = 32'd100;
        mif.rt_data = 32'd7;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        mhi = '0;
        mlo = '0;
        check("midreset_busy", 32'(mif.busy), 32'd0);
        check("midreset_hi", mif.hi, 32'd0);
        check("midreset_lo", mif.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_md(1, 32'd6, 32'd7, "mult_after_reset");

        // Random operations against the reference model.
        for (int k = 0; k < 60; k++) begin
            op = int'($urandom_range(1, 10));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 30);
            if ($urandom_range(0, 1) == 0 && b[31] == 1'b0) b = 32'd0 - b;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 11) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            case (op)
                1, 2, 3, 4: run_md(op, a, b, "rand_md");
                5, 6:       move_from(op, "rand_mf");
                7, 8:       move_to(op, a, "rand_mt");
                default:    undefined_op(op + 3, a, "rand_undef");
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
